if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//   Instruction-fetch front end with a prefetch FIFO. It issues sequential fetches
//   to instruction memory over a req/ack handshake and buffers the returned words.
//   It presents one instruction per cycle to the IF/ID pipeline register.
//   Holds its head under a pipeline stall. Flushes and restarts on a taken branch or jump.
// PARAMETERS
//   DEPTH     4      prefetch FIFO entries (power of 2, >=2)
//   RESET_PC  32'h0  first fetch address after reset
//   NOP_INST  32'h0  word driven on if_Inst while the FIFO is empty
// PORTS
//   Clock        in   1   rising-edge clock
//   Resetn       in   1   asynchronous, active-low reset
//   stall        in   1   from the stall unit; 1 = decode does not accept the head this cycle
//   redirect     in   1   taken branch/jump (pcsource != 0) resolved in decode
//   redirect_pc  in   32  target address (bpc or jpc); bits[1:0] ignored (forced 0)
//   imem_req     out  1   fetch request to instruction memory
//   imem_addr    out  32  fetch address; word aligned
//   imem_ack     in   1   response valid; imem_rdata is valid in the same cycle
//   imem_rdata   in   32  fetched instruction word
//   if_valid     out  1   1 = if_Inst/if_pc4/PC hold a real instruction
//   if_Inst      out  32  head instruction, or NOP_INST when empty
//   if_pc4       out  32  head address + 4, or 0 when empty
//   PC           out  32  head address; fetch pointer when empty
// BEHAVIOUR
//   Reset (async, Resetn=0):
//     fetch pointer fpc=RESET_PC, count=0, state=IDLE, imem_req=0, imem_addr=RESET_PC;
//     if_valid=0, if_Inst=NOP_INST, if_pc4=0, PC=RESET_PC.
//     Reset during any state abandons the outstanding fetch; no late ack is consumed.
//   At most one fetch is outstanding. imem_req and imem_addr stay stable from assertion until imem_ack.
//   FSM:
//     IDLE: if no redirect and count < DEPTH, assert req with addr=fpc -> WAIT.
//     WAIT: on ack, push {rdata, fpc+4}, fpc += 4 -> IDLE.
//       In the same ack cycle, a new req may be issued if space remains (back-to-back fetches).
//     WAIT with redirect and no ack: keep req/addr -> DROP.
//     DROP: on ack, discard rdata -> IDLE. No push and no fpc change.
//   A fetch is issued only when count + outstanding < DEPTH, so a push never overflows.
//   Pop: when if_valid && !stall && !redirect, the head is removed at the clock edge.
//     Push and pop in one cycle leave count unchanged.
//   Redirect (highest priority), in the cycle it is high:
//     count <= 0 and the head is not popped;
//     fpc <= {redirect_pc[31:2],2'b00};
//     an ack arriving in the same cycle is discarded, FSM -> IDLE.
//     The first fetch of the target is issued in the following cycle.
//   Outputs are combinational from the FIFO head. Minimum latency is ack at cycle t ->
//   if_valid=1 at t+1.
//   Empty: if_valid=0, if_Inst=NOP_INST, if_pc4=0, PC=fpc.
//   Full: imem_req stays 0 until a pop occurs.
//   Arithmetic is mod 2^32: fpc=32'hFFFFFFFC advances to 0, and pc4 wraps identically.
//   FIFO read/write pointers are log2(DEPTH) bits and wrap naturally.
// TESTING
//   1 Reset: Resetn=0 -> imem_req=0, if_valid=0, PC=RESET_PC, if_Inst=NOP_INST.
//     Release -> req with addr=0 in the next cycle.
//   2 Stream: ack every cycle with rdata=addr^32'hA5A5A5A5, stall=0 ->
//     if_pc4 = 4,8,12,... on consecutive cycles, with no gaps after the first.
//   3 Fill: stall=1 held -> exactly DEPTH words are queued, then imem_req=0 and the head stays at PC=0.
//     Drop stall -> the words drain in order.
//   4 Redirect in flight: req at addr 0x10 without ack, then redirect to 0x103 ->
//     req held at 0x10 until ack; rdata discarded.
//     Next req at 0x100, and if_valid stays 0 until it is acked.
//   5 Redirect with ack in the same cycle, and the FIFO holding 3 entries ->
//     count=0, the ack word is discarded, and the next req is at the target.
//   6 Wrap/reset mid-op: redirect to 0xFFFFFFFC, ack -> if_pc4=0 and the next addr is 0.
//     Assert Resetn=0 while in WAIT -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: sequential fetches over a req/ack handshake
// into a small prefetch FIFO. The FIFO head drives the IF/ID register.
// It holds the head under stall, and it flushes and restarts on redirect.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP_INST = 32'h0
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_Inst,
    output logic [31:0] if_pc4,
    output logic [31:0] PC
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          push, pop;
    logic [CW-1:0] cnt_after;

    // The FIFO is never empty when count is non-zero, so the head is directly presentable.
    assign if_valid  = (count_q != '0);
    assign if_Inst   = if_valid ? inst_mem[rd_q] : NOP_INST;
    assign if_pc4    = if_valid ? pc_mem[rd_q] + 32'd4 : 32'h0;
    assign PC        = if_valid ? pc_mem[rd_q] : fpc_q;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    // A redirect kills both the pop and the push of that cycle.
    assign pop       = if_valid && !stall && !redirect;
    assign push      = (state_q == S_WAIT) && imem_ack && !redirect;
    // The occupancy after this cycle's push. It decides whether a back-to-back fetch fits.
    assign cnt_after = count_q + CW'(1) - CW'(pop);

    // Next-state logic for the fetch FSM, the fetch pointer and the FIFO bookkeeping.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        wr_d    = push ? wr_q + AW'(1) : wr_q;

        case (state_q)
            S_IDLE: begin
                // Nothing is outstanding here, so the count alone bounds the space.
                if (!redirect && count_q < CW'(DEPTH)) begin
                    req_d   = 1'b1;
                    addr_d  = fpc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // An in-flight request must complete before it can be abandoned.
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem_ack) begin
                    fpc_d = fpc_q + 32'd4;
                    if (cnt_after < CW'(DEPTH)) begin
                        addr_d = fpc_q + 32'd4;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            fpc_d   = {redirect_pc[31:2], 2'b00};
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end
    end

    // Control state registers. Reset abandons any outstanding fetch.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // FIFO storage. It needs no reset because the count gates every read.
    always_ff @(posedge Clock) begin
        if (push) begin
            inst_mem[wr_q] <= imem_rdata;
            pc_mem[wr_q]   <= fpc_q;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue. Inputs change 1ns after each rising edge,
// and outputs are checked at that same point against hand-computed tables.
module tb_if_prefetch_queue;
    logic        Clock = 1'b0;
    logic        Resetn;
    logic        stall, redirect, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_Inst, if_pc4, PC;

    int n_cmp = 0;
    int n_bad = 0;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
        .Clock(Clock), .Resetn(Resetn), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_Inst(if_Inst), .if_pc4(if_pc4), .PC(PC)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        stall, redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc, epc4, einst;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic ack,
                                logic [31:0] dat, logic req, logic [31:0] addr,
                                logic vld, logic [31:0] pc, logic [31:0] pc4,
                                logic [31:0] inst);
        vec_t v;
        v.stall = st;  v.redir = rd;   v.rpc = rpc;  v.ack = ack;  v.rdata = dat;
        v.ereq  = req; v.eaddr = addr; v.evalid = vld;
        v.epc   = pc;  v.epc4 = pc4;   v.einst = inst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc, input logic [31:0] pc4,
                           input logic [31:0] inst);
        chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, vld});
        chk({tag, ".PC"}, PC, pc);
        chk({tag, ".pc4"}, if_pc4, pc4);
        chk({tag, ".inst"}, if_Inst, inst);
    endtask

    initial begin
        // Columns: stall, redir, rpc, ack, rdata | req, addr, valid, PC, pc4, inst
        // Streaming with an ack every cycle.
        tv.push_back(mk(0,0,0,1,32'hA5A5A5A5, 1,32'h4,  1,32'h0,32'h4, 32'hA5A5A5A5));
        tv.push_back(mk(0,0,0,1,32'hA5A5A5A1, 1,32'h8,  1,32'h4,32'h8, 32'hA5A5A5A1));
        tv.push_back(mk(0,0,0,1,32'hA5A5A5AD, 1,32'hC,  1,32'h8,32'hC, 32'hA5A5A5AD));
        tv.push_back(mk(0,0,0,1,32'hA5A5A5A9, 1,32'h10, 1,32'hC,32'h10,32'hA5A5A5A9));
        tv.push_back(mk(0,0,0,0,0,            1,32'h10, 0,32'h10,0,0));
        // Redirect while a fetch is outstanding: the request holds and its data is dropped.
        tv.push_back(mk(0,1,32'h103,0,0,      1,32'h10, 0,32'h100,0,0));
        tv.push_back(mk(0,0,0,0,0,            1,32'h10, 0,32'h100,0,0));
        tv.push_back(mk(0,0,0,1,32'hDEADBEEF, 0,0,      0,32'h100,0,0));
        tv.push_back(mk(0,0,0,0,0,            1,32'h100,0,32'h100,0,0));
        tv.push_back(mk(0,0,0,1,32'h11111111, 1,32'h104,1,32'h100,32'h104,32'h11111111));
        // Fill under stall: the head holds, and the request drops when the FIFO is full.
        tv.push_back(mk(1,0,0,1,32'h22222222, 1,32'h108,1,32'h100,32'h104,32'h11111111));
        tv.push_back(mk(1,0,0,1,32'h33333333, 1,32'h10C,1,32'h100,32'h104,32'h11111111));
        tv.push_back(mk(1,0,0,1,32'h44444444, 0,0,      1,32'h100,32'h104,32'h11111111));
        tv.push_back(mk(1,0,0,0,0,            0,0,      1,32'h100,32'h104,32'h11111111));
        tv.push_back(mk(0,0,0,0,0,            0,0,      1,32'h104,32'h108,32'h22222222));
        tv.push_back(mk(0,0,0,0,0,            1,32'h110,1,32'h108,32'h10C,32'h33333333));
        // Three entries queued, then a redirect that coincides with an ack.
        tv.push_back(mk(1,0,0,1,32'h55555555, 1,32'h114,1,32'h108,32'h10C,32'h33333333));
        tv.push_back(mk(0,1,32'h200,1,32'h66666666, 0,0,0,32'h200,0,0));
        tv.push_back(mk(0,0,0,0,0,            1,32'h200,0,32'h200,0,0));
        // Address wrap at the top of memory.
        tv.push_back(mk(0,1,32'hFFFFFFFE,0,0, 1,32'h200,0,32'hFFFFFFFC,0,0));
        tv.push_back(mk(0,0,0,1,32'h7,        0,0,      0,32'hFFFFFFFC,0,0));
        tv.push_back(mk(0,0,0,0,0,            1,32'hFFFFFFFC,0,32'hFFFFFFFC,0,0));
        tv.push_back(mk(0,0,0,1,32'h77777777, 1,32'h0,  1,32'hFFFFFFFC,32'h0,32'h77777777));

        Resetn = 1'b0; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
        repeat (2) @(posedge Clock);
        #1;
        chk_all("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("reset.addr", imem_addr, 32'h0);
        @(negedge Clock) Resetn = 1'b1;
        @(posedge Clock); #1;
        chk_all("first_req", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);

        foreach (tv[i]) begin
            stall = tv[i].stall; redirect = tv[i].redir; redirect_pc = tv[i].rpc;
            imem_ack = tv[i].ack; imem_rdata = tv[i].rdata;
            @(posedge Clock); #1;
            chk_all($sformatf("vec%0d", i), tv[i].ereq, tv[i].eaddr, tv[i].evalid,
                    tv[i].epc, tv[i].epc4, tv[i].einst);
        end

        // Asynchronous reset in the middle of a cycle while a fetch and a queued word are pending.
        stall = 0; redirect = 0; imem_ack = 0; imem_rdata = 0;
        #2 Resetn = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("async_rst.addr", imem_addr, 32'h0);
        // A late ack is presented during and after the release, and it must not be consumed.
        imem_ack = 1; imem_rdata = 32'hBAD0BAD0;
        @(negedge Clock) Resetn = 1'b1;
        @(posedge Clock); #1;
        chk_all("post_rst", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        imem_rdata = 32'h99;
        @(posedge Clock); #1;
        chk_all("post_rst_fetch", 1, 32'h4, 1, 32'h0, 32'h4, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
